// File: rtl/text_mem_arbiter_if.sv
// text_mem_arbiter_if: host write channel into the text character RAM
interface text_mem_arbiter_if;
  logic        wr_req;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;
  logic        wr_ack;
  logic        wr_err;
  modport master(output wr_req, wr_addr, wr_data, input wr_ack, wr_err);
  modport slave(input wr_req, wr_addr, wr_data, output wr_ack, wr_err);
endinterface

// File: rtl/text_mem_arbiter.sv
// text_mem_arbiter: shares a single-port char RAM between text-mode display fetches and host writes
module text_mem_arbiter #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          pixel_x,
  input  logic [9:0]          pixel_y,
  input  logic                video_on,
  text_mem_arbiter_if.slave   host,
  output logic [11:0]         mem_addr,
  output logic                mem_we,
  output logic [6:0]          mem_wdata,
  input  logic [6:0]          mem_rdata,
  output logic [10:0]         rom_addr,
  input  logic [7:0]          rom_data,
  output logic                pixel_bit
);
  localparam int CELLS = COLS * ROWS;
  localparam int LINES = ROWS * 16;
  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;
  state_t      state;
  logic [6:0]  char_q;
  logic [7:0]  font_q;
  logic [3:0]  font_row;
  logic        f1, f2;
  logic        cell_slot, wrap_slot, slot, in_range;
  logic [9:0]  y_next;
  logic [5:0]  f_row;
  logic [6:0]  f_col;
  logic [3:0]  f_line;
  logic [11:0] f_addr;
  // Decode whether the current x is the cycle before a fetch slot and which cell it loads
  always_comb begin
    y_next    = pixel_y == 10'd524 ? 10'd0 : pixel_y + 10'd1;
    cell_slot = pixel_y < 10'(LINES) && pixel_x[2:0] == 3'd4 && pixel_x < 10'(8 * (COLS - 1));
    wrap_slot = pixel_x == 10'd796 && (pixel_y < 10'(LINES - 1) || pixel_y == 10'd524);
    slot      = cell_slot || wrap_slot;
    f_row     = wrap_slot ? y_next[9:4] : pixel_y[9:4];
    f_col     = wrap_slot ? 7'd0 : pixel_x[9:3] + 7'd1;
    f_line    = wrap_slot ? y_next[3:0] : pixel_y[3:0];
    f_addr    = 12'(f_row * COLS) + 12'(f_col);
    in_range  = host.wr_addr < 12'(CELLS);
  end
  // Display slots pre-empt host writes; a new write needs wr_ack low in the prior cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      host.wr_ack <= 1'b0;
      host.wr_err <= 1'b0;
      font_row    <= '0;
    end else if (slot) begin
      state       <= FETCH;
      mem_addr    <= f_addr;
      mem_we      <= 1'b0;
      host.wr_ack <= 1'b0;
      host.wr_err <= 1'b0;
      font_row    <= f_line;
    end else if (host.wr_req && !host.wr_ack) begin
      state       <= WRITE;
      mem_we      <= in_range;
      host.wr_ack <= 1'b1;
      host.wr_err <= !in_range;
      mem_addr    <= in_range ? host.wr_addr : mem_addr;
      mem_wdata   <= in_range ? host.wr_data : mem_wdata;
    end else begin
      state       <= IDLE;
      mem_we      <= 1'b0;
      host.wr_ack <= 1'b0;
      host.wr_err <= 1'b0;
    end
  end
  // Two-stage char/font pipeline trailing each fetch so a cell lands on its own 8 pixels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f1     <= 1'b0;
      f2     <= 1'b0;
      char_q <= '0;
      font_q <= '0;
    end else begin
      f1     <= state == FETCH;
      f2     <= f1;
      char_q <= f1 ? mem_rdata : char_q;
      font_q <= f2 ? rom_data : font_q;
    end
  end
  assign rom_addr  = {char_q, font_row};
  assign pixel_bit = font_q[3'd7 - pixel_x[2:0]] & video_on;
endmodule

// File: tb/tb_text_mem_arbiter.sv
// tb_text_mem_arbiter: vector table, hand sequences and randomized trials against a spec-level model
module tb_text_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        video_on = 1'b1;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [6:0]  mem_wdata, mem_rdata;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        pixel_bit;
  logic [6:0]  ram_m [0:4095];
  logic [7:0]  rom_m [0:2047];
  int px = 100, py = 490, checks = 0, failures = 0;

  text_mem_arbiter_if host();

  text_mem_arbiter dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .host(host), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rom_addr(rom_addr), .rom_data(rom_data), .pixel_bit(pixel_bit)
  );

  assign pixel_x  = 10'(px);
  assign pixel_y  = 10'(py);
  assign rom_data = rom_m[rom_addr];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= ram_m[mem_addr];
    if (mem_we) ram_m[mem_addr] = mem_wdata;
  end

  typedef struct {int x; int y; bit f; int fa; int fr;} vec_t;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    px++;
    if (px == 800) begin
      px = 0;
      py = (py == 524) ? 0 : py + 1;
    end
    #4;
  endtask

  task automatic place(input int x, input int y);
    px = x;
    py = y;
  endtask

  function automatic bit m_fetch(input int x, input int y);
    if (x == 796) return y < 479 || y == 524;
    return y < 480 && x >= 4 && (x - 4) % 8 == 0 && (x - 4) / 8 <= 78;
  endfunction

  function automatic int m_addr(input int x, input int y);
    if (x == 796) return (y == 524 ? 0 : (y + 1) / 16) * 80;
    return (y / 16) * 80 + (x - 4) / 8 + 1;
  endfunction

  function automatic int m_frow(input int x, input int y);
    if (x == 796) return y == 524 ? 0 : (y + 1) % 16;
    return y % 16;
  endfunction

  task automatic hw(input int a, input int d, output int lat);
    host.wr_addr = 12'(a);
    host.wr_data = 7'(d);
    host.wr_req  = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!host.wr_ack && lat < 10);
    host.wr_req = 1'b0;
    tick();
  endtask

  task automatic trial(input string tag, input int x, input int y, input bit f, input int fa,
                       input int fr, input bit w, input int wa);
    int s, wd, ch, lat;
    bit ir;
    logic [7:0] fb;
    tick();
    s = $urandom_range(0, 2399);
    place(700, 500);
    hw(s, $urandom_range(0, 127), lat);
    chk({tag, " sentinel_lat"}, lat, 1);
    ch = int'(ram_m[fa]);
    wd = $urandom_range(0, 127);
    ir = wa < 2400;
    place(x, y);
    host.wr_addr = 12'(wa);
    host.wr_data = 7'(wd);
    host.wr_req  = w;
    tick();
    if (f) begin
      chk({tag, " fetch_addr"}, mem_addr, fa);
      chk({tag, " fetch_we"}, mem_we, 0);
      chk({tag, " fetch_ack"}, host.wr_ack, 0);
      tick();
    end
    if (w) begin
      chk({tag, " wr_ack"}, host.wr_ack, 1);
      chk({tag, " wr_we"}, mem_we, int'(ir));
      chk({tag, " wr_err"}, host.wr_err, int'(!ir));
      chk({tag, " wr_addr"}, mem_addr, ir ? wa : (f ? fa : s));
      if (ir) chk({tag, " wr_data"}, mem_wdata, wd);
      host.wr_req = 1'b0;
    end else if (!f) begin
      chk({tag, " idle_addr"}, mem_addr, s);
      chk({tag, " idle_we"}, mem_we, 0);
      chk({tag, " idle_ack"}, host.wr_ack, 0);
    end
    if (f) begin
      tick();
      chk({tag, " rom_addr"}, rom_addr, ch * 16 + fr);
      fb = rom_m[ch * 16 + fr];
      for (int i = 0; i < 8; i++) begin
        tick();
        chk({tag, " pixel"}, pixel_bit, int'(fb[7 - i]));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    int lat, acks, errs, wes, n, cyc, old, x, y;
    int adr[4];
    int dat[4];
    int ack_t[4];
    tbl[0]  = '{796, 524, 1, 0, 0};
    tbl[1]  = '{796, 479, 0, 0, 0};
    tbl[2]  = '{796, 478, 1, 2320, 15};
    tbl[3]  = '{4, 18, 1, 81, 2};
    tbl[4]  = '{628, 0, 1, 79, 0};
    tbl[5]  = '{4, 479, 1, 2321, 15};
    tbl[6]  = '{4, 480, 0, 0, 0};
    tbl[7]  = '{5, 100, 0, 0, 0};
    tbl[8]  = '{636, 100, 0, 0, 0};
    tbl[9]  = '{796, 523, 0, 0, 0};
    tbl[10] = '{796, 29, 1, 80, 14};
    tbl[11] = '{796, 15, 1, 80, 0};
    tbl[12] = '{3, 0, 0, 0, 0};
    for (int i = 0; i < 4096; i++) ram_m[i] = 7'($urandom);
    for (int i = 0; i < 2048; i++) rom_m[i] = 8'($urandom);
    rom_m[16'h41 * 16 + 2] = 8'b1000_0001;
    host.wr_req  = 1'b0;
    host.wr_addr = '0;
    host.wr_data = '0;

    tick();
    tick();
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset wr_ack", host.wr_ack, 0);
    chk("reset wr_err", host.wr_err, 0);
    chk("reset rom_addr", rom_addr, 0);
    chk("reset pixel", pixel_bit, 0);
    reset = 1'b1;
    tick();
    tick();
    tick();
    chk("post_reset pixel", pixel_bit, 0);

    place(100, 490);
    hw(81, 16'h41, lat);
    chk("write81 lat", lat, 1);
    chk("write81 ram", ram_m[81], 16'h41);
    place(4, 18);
    tick();
    tick();
    tick();
    tick();
    chk("disp x8", pixel_bit, 1);
    for (int i = 9; i <= 14; i++) begin
      tick();
      chk("disp mid", pixel_bit, 0);
    end
    tick();
    chk("disp x15", pixel_bit, 1);
    video_on = 1'b0;
    #1;
    chk("disp video_off", pixel_bit, 0);
    video_on = 1'b1;

    tick();
    place(12, 18);
    host.wr_addr = 12'd500;
    host.wr_data = 7'h22;
    host.wr_req  = 1'b1;
    tick();
    chk("collide fetch_addr", mem_addr, 82);
    chk("collide ack_early", host.wr_ack, 0);
    tick();
    chk("collide ack", host.wr_ack, 1);
    chk("collide we", mem_we, 1);
    chk("collide addr", mem_addr, 500);
    host.wr_req = 1'b0;
    tick();
    chk("collide ram", ram_m[500], 16'h22);

    place(100, 490);
    host.wr_addr = 12'd2400;
    host.wr_data = 7'h7f;
    host.wr_req  = 1'b1;
    acks = 0; errs = 0; wes = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      wes += int'(mem_we);
      if (host.wr_ack) begin
        acks++;
        errs += int'(host.wr_err);
        host.wr_req = 1'b0;
      end
    end
    chk("oor acks", acks, 1);
    chk("oor errs", errs, 1);
    chk("oor we", wes, 0);

    adr = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) dat[i] = $urandom_range(0, 127);
    place(100, 490);
    host.wr_addr = 12'(adr[0]);
    host.wr_data = 7'(dat[0]);
    host.wr_req  = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 30) begin
      tick();
      cyc++;
      if (host.wr_ack) begin
        ack_t[n] = cyc;
        n++;
        if (n < 4) begin
          host.wr_addr = 12'(adr[n]);
          host.wr_data = 7'(dat[n]);
        end else host.wr_req = 1'b0;
      end
    end
    chk("b2b acks", n, 4);
    if (n == 4) for (int i = 1; i < 4; i++) chk("b2b spacing", ack_t[i] - ack_t[0], 2 * i);
    tick();
    for (int i = 0; i < 4; i++) chk("b2b ram", ram_m[adr[i]], dat[i]);

    place(100, 490);
    tick();
    old = int'(ram_m[600]);
    host.wr_addr = 12'd600;
    host.wr_data = 7'(old ^ 16'h55);
    host.wr_req  = 1'b1;
    tick();
    chk("rstw ack_before", host.wr_ack, 1);
    reset = 1'b0;
    #1;
    chk("rstw we", mem_we, 0);
    chk("rstw ack", host.wr_ack, 0);
    tick();
    chk("rstw ram_kept", ram_m[600], old);
    reset = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (host.wr_ack) begin
        acks++;
        host.wr_req = 1'b0;
      end
    end
    chk("rstw reacks", acks, 1);
    chk("rstw ram", ram_m[600], old ^ 16'h55);

    foreach (tbl[i]) trial("vec", tbl[i].x, tbl[i].y, tbl[i].f, tbl[i].fa, tbl[i].fr, 1'b0, 0);

    for (int t = 0; t < 250; t++) begin
      case ($urandom_range(0, 3))
        0: x = $urandom_range(0, 799);
        3: x = 796;
        default: x = 8 * $urandom_range(0, 79) + 4;
      endcase
      y = ($urandom_range(0, 3) == 0) ? 470 + $urandom_range(0, 14) : $urandom_range(0, 524);
      if ($urandom_range(0, 7) == 0) y = 524;
      trial("rand", x, y, m_fetch(x, y), m_addr(x, y), m_frow(x, y),
            1'($urandom_range(0, 1)), $urandom_range(0, 2599));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/text_mem_arbiter.md
TEXT_MEM_ARBITER -- requirements
Module: text_mem_arbiter

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text columns per line (8-pixel cells).
REQ-002 SHALL have parameter ROWS, default 30, meaning text rows (16-line cells); cell count = COLS*ROWS = 2400.
REQ-003 SHALL have port clk, input, 1, pixel clock; pixel_x advances once per clk.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports pixel_x and pixel_y, input, 10 each, sync-generator position (h total 800, v total 525).
REQ-006 SHALL have port video_on, input, 1, visible-area flag from the sync generator.
REQ-007 SHALL have port wr_req, input, 1, host write request, held with wr_addr and wr_data stable until wr_ack.
REQ-008 SHALL have ports wr_addr, input, 12, and wr_data, input, 7, giving the target cell (row*COLS+col) and the char code.
REQ-009 SHALL have ports wr_ack and wr_err, output, 1 each, as one-cycle acknowledge and out-of-range flag.
REQ-010 SHALL have ports mem_addr, output, 12; mem_we, output, 1; mem_wdata, output, 7; mem_rdata, input, 7, for the shared single-port char RAM, read data valid the cycle after the address.
REQ-011 SHALL have ports rom_addr, output, 11, equal to {char_code[6:0], font_row[3:0]}, and rom_data, input, 8, from the combinational font ROM.
REQ-012 SHALL have port pixel_bit, output, 1, font pixel for the current position.

Function
REQ-013 SHALL use FSM states IDLE, FETCH and WRITE, where the registered state names the memory operation of the current cycle.
REQ-014 Fetch slots: x = 8k+5 for k = 0..78 with y < 480 (fetches col k+1, row y[8:4]); x = 797 fetches col 0 of row (y+1)[8:4] if y < 479, or row 0 if y = 524; there is no slot when y = 479..523.
REQ-015 SHALL enter FETCH in a cycle exactly when the previous cycle was x = slot-1, so that FETCH coincides with the slot cycle.
REQ-016 SHALL drive mem_addr = row*COLS+col with mem_we = 0 in FETCH, and latch font_row (y[3:0], or (y+1)[3:0] for the x = 797 slot, with 0 for y = 524).
REQ-017 SHALL capture mem_rdata into char_q at slot+1 and drive rom_addr = {char_q, font_row} at slot+2.
REQ-018 SHALL load font_q from rom_data at the end of slot+2.
REQ-019 SHALL drive pixel_bit = font_q[7 - pixel_x[2:0]] AND video_on, combinationally.
REQ-020 Net effect of REQ-017 to REQ-019: cell col c, pixel row r appears at x = 8c..8c+7.
REQ-021 Display has absolute priority: WRITE is never entered in a cycle that is entered as FETCH.
REQ-022 SHALL enter WRITE from a non-FETCH cycle when wr_req = 1 and wr_ack was 0 in the previous cycle; a write blocked by a FETCH waits exactly one cycle.
REQ-023 In WRITE: wr_ack = 1; if wr_addr < 2400, mem_we = 1, mem_addr = wr_addr and mem_wdata = wr_data, else mem_we = 0 and wr_err = 1.
REQ-024 Host writes SHALL sustain one write per 2 cycles; a wr_req still high in the ack cycle is treated as the next transaction.
REQ-025 SHALL hold the state in IDLE and keep mem_we = 0 when there is neither a slot nor a request.
REQ-026 mem_addr, mem_we, mem_wdata, wr_ack and wr_err SHALL be registered outputs.

Reset
REQ-027 On reset low, SHALL asynchronously force state = IDLE and clear mem_addr, mem_we, mem_wdata, wr_ack, wr_err, char_q, font_q and font_row to 0, making pixel_bit = 0.
REQ-028 A write in progress at reset SHALL be abandoned with no ack, and the host SHALL re-request it.
REQ-029 After reset release, SHALL perform the first fetch at the next slot, with garbage-free (zero) pixels until then.

Verification
REQ-030 Display fetch: RAM cell 81 = 0x41 and ROM(0x41, row 2) = 8'b1000_0001, y = 18 -> pixel_bit = 1 at x = 8 and x = 15, and 0 at x = 9..14.
REQ-031 Collision: wr_req rising at x = 12 (slot pre-cycle) -> FETCH at x = 13, WRITE with wr_ack at x = 14, mem_addr = wr_addr.
REQ-032 Out-of-range: wr_addr = 2400 -> single wr_ack with wr_err = 1, mem_we never 1.
REQ-033 Line wrap: y = 524, x = 797 -> mem_addr = 0 and font_row = 0; y = 479, x = 797 -> no FETCH; y = 478, x = 797 -> mem_addr = 2320 (row 29).
REQ-034 Back-to-back: wr_req held for 4 distinct writes in blanking -> wr_ack at cycles t, t+2, t+4, t+6.
REQ-035 Reset mid-write: reset asserted during WRITE -> mem_we = 0 and wr_ack = 0 immediately; a re-request after release is acked once.
